decoder_seq: RTL

Parametrised, registered one-hot decoder: the successor to the combinational 2-to-4 enable decoder. Adds a configurable select width, a registered output, and an autonomous scan mode that steps the active output through all positions at a programmable rate. Intended as the row/digit select driver for multiplexed outputs such as LED matrices or seven-segment digit enables, fed directly from control logic.

---
 rtl/decoder_seq_if.sv | 17 +
 rtl/decoder_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/decoder_seq_if.sv
// Select/enable bus between control logic and the decoder_seq row/digit driver.
// master drives en/mode/a; slave (the decoder) returns y/idx/wrap.
interface decoder_seq_if #(
  parameter int SEL_W = 2
) ();
  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] a;
  logic [OUT_W-1:0] y;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (output en, mode, a, input y, idx, wrap);
  modport slave  (input en, mode, a, output y, idx, wrap);
endinterface

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with optional autonomous scan mode.
// Scan mode, prescaler and wrap pulse exist only when DECODER_SEQ_SCAN_EN is defined.
module decoder_seq #(
  parameter int SEL_W    = 2,
  parameter int SCAN_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  decoder_seq_if.slave bus
);
  localparam int OUT_W = 2 ** SEL_W;

  if (SCAN_DIV < 1 || SCAN_DIV > 65535) begin : g_bad_scan_div
    $error("decoder_seq: SCAN_DIV must be in 1..65535");
  end

`ifdef DECODER_SEQ_SCAN_EN
  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  localparam logic [15:0]      DIV_LAST = 16'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] IDX_ONE  = SEL_W'(1);
  localparam logic [SEL_W-1:0] IDX_MAX  = SEL_W'(OUT_W - 1);
`else
  typedef enum logic [1:0] {IDLE, DIRECT} state_t;
`endif

  function automatic logic [OUT_W-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [OUT_W-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] y_q, y_d;
`ifdef DECODER_SEQ_SCAN_EN
  logic             wrap_q, wrap_d;
  logic [15:0]      presc_q, presc_d;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      y_q     <= '0;
`ifdef DECODER_SEQ_SCAN_EN
      wrap_q  <= 1'b0;
      presc_q <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
`ifdef DECODER_SEQ_SCAN_EN
      wrap_q  <= wrap_d;
      presc_q <= presc_d;
`endif
    end
  end

  // Next-state: en dominates, then mode picks the active state.
  always_comb begin
    state_d = DIRECT;
    if (!bus.en) begin
      state_d = IDLE;
`ifdef DECODER_SEQ_SCAN_EN
    end else if (bus.mode) begin
      state_d = SCAN;
`endif
    end
  end

  // Register next-values, keyed on the state being entered.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable and no latch is inferred.
    idx_d = idx_q;
    y_d   = y_q;
`ifdef DECODER_SEQ_SCAN_EN
    wrap_d  = 1'b0;
    presc_d = '0;
`endif
    case (state_d)
      IDLE: begin
        idx_d = '0;
        y_d   = '0;
      end
      DIRECT: begin
        idx_d = bus.a;
        y_d   = onehot(bus.a);
      end
`ifdef DECODER_SEQ_SCAN_EN
      SCAN: begin
        if (state_q != SCAN) begin
          // Entry loads the start index; wrap is never raised here.
          idx_d = bus.a;
          y_d   = onehot(bus.a);
        end else if (presc_q == DIV_LAST) begin
          idx_d  = idx_q + IDX_ONE;
          y_d    = onehot(idx_q + IDX_ONE);
          wrap_d = (idx_q == IDX_MAX);
        end else begin
          presc_d = presc_q + 16'd1;
        end
      end
`endif
      default: begin
        idx_d = '0;
        y_d   = '0;
      end
    endcase
  end

  assign bus.y   = y_q;
  assign bus.idx = idx_q;
`ifdef DECODER_SEQ_SCAN_EN
  assign bus.wrap = wrap_q;
`else
  assign bus.wrap = 1'b0;
  logic unused_mode;
  assign unused_mode = bus.mode;
`endif
endmodule
